// File: rtl/default_slave_pkg.sv
// Shared AXI widths and response codes for the default (unmapped) slave.
// Mirrors the values the interconnect uses for its slave-side ports.
package default_slave_pkg;

    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = 4;
    localparam int AXI_IDS_BITS   = 8;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/default_slave.sv
// AXI4 responder for unmapped addresses: accepts any write or read burst and
// terminates it with DECERR so a stray master access never stalls the fabric.
module default_slave
    import default_slave_pkg::*;
(
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [AXI_IDS_BITS-1:0]   AWID_S,
    input  logic [AXI_ADDR_BITS-1:0]  AWADDR_S,
    input  logic [AXI_LEN_BITS-1:0]   AWLEN_S,
    input  logic [AXI_SIZE_BITS-1:0]  AWSIZE_S,
    input  logic [AXI_BURST_BITS-1:0] AWBURST_S,
    input  logic                      AWVALID_S,
    output logic                      AWREADY_S,
    input  logic [AXI_DATA_BITS-1:0]  WDATA_S,
    input  logic [AXI_STRB_BITS-1:0]  WSTRB_S,
    input  logic                      WLAST_S,
    input  logic                      WVALID_S,
    output logic                      WREADY_S,
    output logic [AXI_IDS_BITS-1:0]   BID_S,
    output logic [1:0]                BRESP_S,
    output logic                      BVALID_S,
    input  logic                      BREADY_S,
    input  logic [AXI_IDS_BITS-1:0]   ARID_S,
    input  logic [AXI_ADDR_BITS-1:0]  ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]   ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0]  ARSIZE_S,
    input  logic [AXI_BURST_BITS-1:0] ARBURST_S,
    input  logic                      ARVALID_S,
    output logic                      ARREADY_S,
    output logic [AXI_IDS_BITS-1:0]   RID_S,
    output logic [AXI_DATA_BITS-1:0]  RDATA_S,
    output logic [1:0]                RRESP_S,
    output logic                      RLAST_S,
    output logic                      RVALID_S,
    input  logic                      RREADY_S
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e                w_state_r, w_state_s;
    r_state_e                r_state_r, r_state_s;
    logic [AXI_IDS_BITS-1:0] bid_r, rid_r;
    logic [AXI_LEN_BITS-1:0] rlen_r, rcnt_r;
    logic                    aw_hs_s, w_last_hs_s, b_hs_s, ar_hs_s, r_hs_s, r_last_s;
    logic                    unused_s;

    // Address, size, burst and write payload have no effect on a DECERR reply
    assign unused_s = ^{AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, WDATA_S, WSTRB_S,
                        ARADDR_S, ARSIZE_S, ARBURST_S};

    assign aw_hs_s     = AWVALID_S & AWREADY_S;
    assign w_last_hs_s = WVALID_S & WREADY_S & WLAST_S;
    assign b_hs_s      = BVALID_S & BREADY_S;
    assign ar_hs_s     = ARVALID_S & ARREADY_S;
    assign r_hs_s      = RVALID_S & RREADY_S;
    assign r_last_s    = (rcnt_r == rlen_r);

    // Write path: state register and latched AWID
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_r <= W_IDLE;
            bid_r     <= {AXI_IDS_BITS{1'b0}};
        end else begin
            w_state_r <= w_state_s;
            if (aw_hs_s) begin
                bid_r <= AWID_S;
            end
        end
    end

    // Write path next state; beat count is deliberately ignored, WLAST ends the burst
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s)     w_state_s = W_DATA; else w_state_s = W_IDLE;
            W_DATA:  if (w_last_hs_s) w_state_s = W_RESP; else w_state_s = W_DATA;
            W_RESP:  if (b_hs_s)      w_state_s = W_IDLE; else w_state_s = W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write path outputs decoded from state only
    always_comb begin
        AWREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        BRESP_S   = AXI_RESP_OKAY;
        BID_S     = {AXI_IDS_BITS{1'b0}};
        case (w_state_r)
            W_IDLE:  AWREADY_S = 1'b1;
            W_DATA:  WREADY_S  = 1'b1;
            W_RESP: begin
                BVALID_S = 1'b1;
                BRESP_S  = AXI_RESP_DECERR;
                BID_S    = bid_r;
            end
            default: AWREADY_S = 1'b0;
        endcase
    end

    // Read path: state, latched ARID/ARLEN and beat counter (holds at LEN on the last beat)
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_r <= R_IDLE;
            rid_r     <= {AXI_IDS_BITS{1'b0}};
            rlen_r    <= {AXI_LEN_BITS{1'b0}};
            rcnt_r    <= {AXI_LEN_BITS{1'b0}};
        end else begin
            r_state_r <= r_state_s;
            if (ar_hs_s) begin
                rid_r  <= ARID_S;
                rlen_r <= ARLEN_S;
                rcnt_r <= {AXI_LEN_BITS{1'b0}};
            end else if (r_hs_s && !r_last_s) begin
                rcnt_r <= rcnt_r + {{(AXI_LEN_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Read path next state
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s)             r_state_s = R_DATA; else r_state_s = R_IDLE;
            R_DATA:  if (r_hs_s && r_last_s) r_state_s = R_IDLE; else r_state_s = R_DATA;
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read path outputs decoded from state only; data is always zero
    always_comb begin
        ARREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        RRESP_S   = AXI_RESP_OKAY;
        RID_S     = {AXI_IDS_BITS{1'b0}};
        RLAST_S   = 1'b0;
        RDATA_S   = {AXI_DATA_BITS{1'b0}};
        case (r_state_r)
            R_IDLE:  ARREADY_S = 1'b1;
            R_DATA: begin
                RVALID_S = 1'b1;
                RRESP_S  = AXI_RESP_DECERR;
                RID_S    = rid_r;
                RLAST_S  = r_last_s;
            end
            default: ARREADY_S = 1'b0;
        endcase
    end

endmodule
